pipeline_control_unit: RTL and testbench

//  Next-generation MIPS control unit for the pipelined datapath. Decodes the ID-stage instruction into a

---
 rtl/pipeline_control_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_unit
// Purpose  : Control path for the pipelined MIPS datapath. Decodes the
//            ID-stage instruction into a control bundle and carries it through
//            the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use
//            hazards, generates EX forwarding selects, applies flush/freeze,
//            and tracks a sticky halt once HALT retires.
// Ports    : CLK, nRST (async, active low)   clock / reset
//            instr[31:0]                     ID-stage instruction
//            freeze                          hold every control register
//            flush                           squash the ID-stage instruction
//            hazard_stall                    load-use stall request
//            ex_*   (alu_op, alu_src, extop, pc_src, bne)  EX controls
//            fwd_a, fwd_b                    EX operand forwarding selects
//            mem_memwr, mem_memren           MEM controls
//            wb_regwr, wb_memtoreg, wb_wsel  WB controls
//            halt                            sticky HALT-retired flag
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_control_unit #(
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 4,
  parameter int HAZARD_EN = 1,
  parameter int FWD_EN    = 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [31:0]        instr,
  input  logic               freeze,
  input  logic               flush,
  output logic               hazard_stall,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_extop,
  output logic [1:0]         ex_pc_src,
  output logic               ex_bne,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_memwr,
  output logic               mem_memren,
  output logic               wb_regwr,
  output logic               wb_memtoreg,
  output logic [REG_W-1:0]   wb_wsel,
  output logic               halt
);

  // ALU operation encoding (aluop_t)
  localparam logic [ALUOP_W-1:0] c_ALU_SLL  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_ALU_SRL  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_ALU_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] c_ALU_SUB  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_ALU_AND  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] c_ALU_OR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] c_ALU_XOR  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] c_ALU_NOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] c_ALU_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] c_ALU_SLTU = ALUOP_W'(9);

  localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_J    = 6'h02, c_OP_JAL  = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04, c_OP_BNE  = 6'h05, c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A, c_OP_SLTIU = 6'h0B, c_OP_ANDI = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D, c_OP_XORI = 6'h0E, c_OP_LUI  = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23, c_OP_SW   = 6'h2B, c_OP_HALT = 6'h3F;

  localparam logic [5:0] c_FN_SLL  = 6'h00, c_FN_SRL  = 6'h02, c_FN_JR  = 6'h08;
  localparam logic [5:0] c_FN_ADDU = 6'h21, c_FN_SUBU = 6'h23, c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25, c_FN_XOR  = 6'h26, c_FN_NOR = 6'h27;
  localparam logic [5:0] c_FN_SLT  = 6'h2A, c_FN_SLTU = 6'h2B;

  typedef struct packed {
    logic               halt;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               extop;
    logic [1:0]         pc_src;
    logic               bne;
    logic               memwr;
    logic               memren;
    logic               regwr;
    logic               memtoreg;
    logic [REG_W-1:0]   wsel;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
  } idex_t;

  typedef struct packed {
    logic             halt;
    logic             memwr;
    logic             memren;
    logic             regwr;
    logic             memtoreg;
    logic [REG_W-1:0] wsel;
  } exmem_t;

  typedef struct packed {
    logic             halt;
    logic             regwr;
    logic             memtoreg;
    logic [REG_W-1:0] wsel;
  } memwb_t;

  logic [5:0]       w_op, w_fn;
  logic [REG_W-1:0] w_rs, w_rt, w_rd;
  logic             w_unused_shamt;
  idex_t            w_dec, w_idex_d, r_idex;
  exmem_t           w_exmem_d, r_exmem;
  memwb_t           w_memwb_d, r_memwb;
  logic             r_halt;
  logic             w_halt;
  logic             w_hazard;

  assign w_op = instr[31:26];
  assign w_fn = instr[5:0];
  assign w_rs = REG_W'(instr[25:21]);
  assign w_rt = REG_W'(instr[20:16]);
  assign w_rd = REG_W'(instr[15:11]);
  assign w_unused_shamt = ^instr[10:6];

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_dec = '0;
    case (w_op)
      c_OP_RTYPE: begin
        w_dec.rs    = w_rs;
        w_dec.rt    = w_rt;
        w_dec.regwr = 1'b1;
        w_dec.wsel  = w_rd;
        case (w_fn)
          c_FN_SLL:  w_dec.alu_op = c_ALU_SLL;
          c_FN_SRL:  w_dec.alu_op = c_ALU_SRL;
          c_FN_ADDU: w_dec.alu_op = c_ALU_ADD;
          c_FN_SUBU: w_dec.alu_op = c_ALU_SUB;
          c_FN_AND:  w_dec.alu_op = c_ALU_AND;
          c_FN_OR:   w_dec.alu_op = c_ALU_OR;
          c_FN_XOR:  w_dec.alu_op = c_ALU_XOR;
          c_FN_NOR:  w_dec.alu_op = c_ALU_NOR;
          c_FN_SLT:  w_dec.alu_op = c_ALU_SLT;
          c_FN_SLTU: w_dec.alu_op = c_ALU_SLTU;
          c_FN_JR: begin
            w_dec.regwr  = 1'b0;
            w_dec.wsel   = '0;
            w_dec.pc_src = 2'b11;
          end
          default:   w_dec = '0;
        endcase
      end
      c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU, c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
        w_dec.rs      = w_rs;
        w_dec.rt      = w_rt;
        w_dec.regwr   = 1'b1;
        w_dec.wsel    = w_rt;
        w_dec.alu_src = 1'b1;
        w_dec.extop   = (w_op == c_OP_ADDIU) || (w_op == c_OP_SLTI) || (w_op == c_OP_SLTIU);
        case (w_op)
          c_OP_SLTI:  w_dec.alu_op = c_ALU_SLT;
          c_OP_SLTIU: w_dec.alu_op = c_ALU_SLTU;
          c_OP_ANDI:  w_dec.alu_op = c_ALU_AND;
          c_OP_ORI:   w_dec.alu_op = c_ALU_OR;
          c_OP_XORI:  w_dec.alu_op = c_ALU_XOR;
          // LUI: datapath presents imm<<16 on B and rs is $0, so an add yields it
          default:    w_dec.alu_op = c_ALU_ADD;
        endcase
      end
      c_OP_LW: begin
        w_dec.rs       = w_rs;
        w_dec.rt       = w_rt;
        w_dec.regwr    = 1'b1;
        w_dec.wsel     = w_rt;
        w_dec.memren   = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.alu_src  = 1'b1;
        w_dec.extop    = 1'b1;
        w_dec.alu_op   = c_ALU_ADD;
      end
      c_OP_SW: begin
        w_dec.rs      = w_rs;
        w_dec.rt      = w_rt;
        w_dec.memwr   = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.extop   = 1'b1;
        w_dec.alu_op  = c_ALU_ADD;
      end
      c_OP_BEQ, c_OP_BNE: begin
        w_dec.rs     = w_rs;
        w_dec.rt     = w_rt;
        w_dec.alu_op = c_ALU_SUB;
        w_dec.extop  = 1'b1;
        w_dec.pc_src = 2'b01;
        w_dec.bne    = (w_op == c_OP_BNE);
      end
      c_OP_J:    w_dec.pc_src = 2'b10;
      c_OP_JAL: begin
        w_dec.pc_src = 2'b10;
        w_dec.regwr  = 1'b1;
        w_dec.wsel   = REG_W'(31);
      end
      c_OP_HALT: w_dec.halt = 1'b1;
      default:   w_dec = '0;
    endcase
    // $0 is hard-wired: a write to it is never a write
    if (w_dec.wsel == '0) w_dec.regwr = 1'b0;
  end

  // ---------------------------------------------------------------- hazard
  generate
    if (HAZARD_EN != 0) begin : g_hazard
      logic w_uses_rt;
      assign w_uses_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_SW) ||
                         (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);
      assign w_hazard = r_idex.memren && (r_idex.wsel != '0) &&
                        ((r_idex.wsel == w_rs) || (w_uses_rt && (r_idex.wsel == w_rt)));
    end else begin : g_no_hazard
      assign w_hazard = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------- next state
  assign w_halt = r_halt | r_memwb.halt;

  // flush outranks stall, but both resolve to the same bubble in ID/EX
  assign w_idex_d  = (flush || w_hazard || w_halt) ? '0 : w_dec;
  assign w_exmem_d = w_halt ? '0 : '{halt: r_idex.halt, memwr: r_idex.memwr,
                                     memren: r_idex.memren, regwr: r_idex.regwr,
                                     memtoreg: r_idex.memtoreg, wsel: r_idex.wsel};
  assign w_memwb_d = '{halt: r_exmem.halt, regwr: r_exmem.regwr,
                       memtoreg: r_exmem.memtoreg, wsel: r_exmem.wsel};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
      r_halt  <= 1'b0;
    end else begin
      if (r_memwb.halt) r_halt <= 1'b1;
      if (!freeze) begin
        r_idex  <= w_idex_d;
        r_exmem <= w_exmem_d;
        r_memwb <= w_memwb_d;
      end
    end
  end

  // ---------------------------------------------------------------- forwarding
  generate
    if (FWD_EN != 0) begin : g_fwd
      always_comb begin
        fwd_a = 2'b00;
        if (r_exmem.regwr && (r_exmem.wsel == r_idex.rs) && (r_idex.rs != '0))
          fwd_a = 2'b01;
        else if (r_memwb.regwr && (r_memwb.wsel == r_idex.rs) && (r_idex.rs != '0))
          fwd_a = 2'b10;
      end
      always_comb begin
        fwd_b = 2'b00;
        if (r_exmem.regwr && (r_exmem.wsel == r_idex.rt) && (r_idex.rt != '0))
          fwd_b = 2'b01;
        else if (r_memwb.regwr && (r_memwb.wsel == r_idex.rt) && (r_idex.rt != '0))
          fwd_b = 2'b10;
      end
    end else begin : g_no_fwd
      assign fwd_a = 2'b00;
      assign fwd_b = 2'b00;
    end
  endgenerate

  // ---------------------------------------------------------------- outputs
  assign hazard_stall = w_hazard;
  assign ex_alu_op    = r_idex.alu_op;
  assign ex_alu_src   = r_idex.alu_src;
  assign ex_extop     = r_idex.extop;
  assign ex_pc_src    = r_idex.pc_src;
  assign ex_bne       = r_idex.bne;
  assign mem_memwr    = r_exmem.memwr;
  assign mem_memren   = r_exmem.memren;
  assign wb_regwr     = r_memwb.regwr;
  assign wb_memtoreg  = r_memwb.memtoreg;
  assign wb_wsel      = r_memwb.wsel;
  assign halt         = w_halt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_control_unit
// Purpose  : Directed self-checking bench for pipeline_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_control_unit;

  logic        CLK, nRST, freeze, flush;
  logic [31:0] instr;
  logic        hazard_stall, ex_alu_src, ex_extop, ex_bne;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_pc_src, fwd_a, fwd_b;
  logic        mem_memwr, mem_memren, wb_regwr, wb_memtoreg, halt;
  logic [4:0]  wb_wsel;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_control_unit #(.REG_W(5), .ALUOP_W(4), .HAZARD_EN(1), .FWD_EN(1)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .freeze(freeze), .flush(flush),
    .hazard_stall(hazard_stall), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_extop(ex_extop), .ex_pc_src(ex_pc_src), .ex_bne(ex_bne),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_memwr(mem_memwr), .mem_memren(mem_memren),
    .wb_regwr(wb_regwr), .wb_memtoreg(wb_memtoreg), .wb_wsel(wb_wsel), .halt(halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    // ---- 1: reset and basic latency
    nRST = 1'b0; freeze = 1'b0; flush = 1'b0;
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);           // ADDU $3,$1,$2
    tick(); tick();
    chk("rst_ex_alu_op", ex_alu_op, 0);
    chk("rst_pc_src",    ex_pc_src, 0);
    chk("rst_mem",       {mem_memwr, mem_memren}, 0);
    chk("rst_wb",        {wb_regwr, wb_memtoreg, wb_wsel}, 0);
    chk("rst_halt",      {halt, hazard_stall, fwd_a, fwd_b}, 0);
    nRST = 1'b1;
    tick();
    chk("t1_ex_alu_op", ex_alu_op, 2);
    chk("t1_ex_alu_src", ex_alu_src, 0);
    chk("t1_wb_early",  wb_regwr, 0);
    instr = NOP;
    tick(); tick();
    chk("t1_wb", {wb_regwr, wb_wsel}, {1'b1, 5'd3});

    // ---- 2: load-use stall then WB forward
    instr = itype(6'h23, 5'd1, 5'd5, 16'd0);            // LW $5,0($1)
    tick();
    instr = rtype(5'd5, 5'd2, 5'd6, 6'h21);           // ADDU $6,$5,$2
    #1 chk("t2_stall", hazard_stall, 1);
    tick();
    chk("t2_bubble",    {ex_alu_op, ex_alu_src}, 0);
    chk("t2_mem_ren",   mem_memren, 1);
    chk("t2_stall_end", hazard_stall, 0);
    tick();
    chk("t2_ex_op",  ex_alu_op, 2);
    chk("t2_fwd",    {fwd_a, fwd_b}, 4'b1000);
    chk("t2_wb_lw",  {wb_regwr, wb_memtoreg, wb_wsel}, {1'b1, 1'b1, 5'd5});
    chk("t2_stall_once", hazard_stall, 0);
    instr = NOP;

    // ---- 3: EX/MEM forward, MEM/WB forward, $0 never forwards
    instr = rtype(5'd1, 5'd2, 5'd4, 6'h21);           // ADDU $4,$1,$2
    tick();
    instr = rtype(5'd4, 5'd4, 5'd7, 6'h23);           // SUBU $7,$4,$4
    tick();
    chk("t3_sub_op",  ex_alu_op, 3);
    chk("t3_fwd_mem", {fwd_a, fwd_b}, 4'b0101);
    instr = rtype(5'd4, 5'd4, 5'd0, 6'h21);           // ADDU $0,$4,$4
    tick();
    chk("t3_fwd_wb", {fwd_a, fwd_b}, 4'b1010);
    instr = rtype(5'd0, 5'd0, 5'd8, 6'h21);           // ADDU $8,$0,$0
    tick();
    chk("t3_fwd_r0",  {fwd_a, fwd_b}, 4'b0000);
    chk("t3_wb_sub",  {wb_regwr, wb_wsel}, {1'b1, 5'd7});
    instr = NOP;
    tick();
    chk("t3_wb_r0", {wb_regwr, wb_wsel}, 0);

    // ---- 4: freeze holds everything
    instr = itype(6'h0D, 5'd1, 5'd9, 16'd5);            // ORI $9,$1,5
    tick();
    chk("t4_ori", {ex_alu_op, ex_alu_src, ex_extop}, {4'd5, 1'b1, 1'b0});
    instr = itype(6'h2B, 5'd2, 5'd9, 16'd4);            // SW $9,4($2)
    tick();
    chk("t4_sw_fwdb", {fwd_a, fwd_b}, 4'b0001);
    instr = rtype(5'd9, 5'd9, 5'd10, 6'h21);          // ADDU $10,$9,$9
    tick();
    instr = itype(6'h0E, 5'd1, 5'd11, 16'd1);           // XORI $11,$1,1
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_frozen", {ex_alu_op, ex_alu_src, fwd_a, fwd_b, mem_memwr, mem_memren,
                        wb_regwr, wb_memtoreg, wb_wsel},
                       {4'd2, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9});
    end
    freeze = 1'b0;
    tick();
    chk("t4_resume_ex", {ex_alu_op, ex_alu_src, ex_extop, fwd_a, fwd_b},
                        {4'd6, 1'b1, 1'b0, 2'b00, 2'b00});
    chk("t4_resume_mw", {mem_memwr, wb_regwr, wb_wsel}, 0);

    // ---- 5: flush with and without a simultaneous stall
    instr = itype(6'h23, 5'd1, 5'd11, 16'd0);           // LW $11,0($1)
    tick();
    instr = rtype(5'd11, 5'd0, 5'd12, 6'h21);         // ADDU $12,$11,$0
    flush = 1'b1;
    #1 chk("t5_stall_raw", hazard_stall, 1);
    tick();
    chk("t5_squash", {ex_alu_op, ex_alu_src}, 0);
    chk("t5_mem_lw", mem_memren, 1);
    flush = 1'b0;
    instr = itype(6'h0D, 5'd0, 5'd13, 16'd1);           // ORI $13,$0,1
    #1 chk("t5_no_stall", hazard_stall, 0);
    tick();
    chk("t5_next", {ex_alu_op, ex_alu_src, ex_extop}, {4'd5, 1'b1, 1'b0});
    instr = itype(6'h09, 5'd1, 5'd14, 16'd7);           // ADDIU $14,$1,7
    flush = 1'b1;
    tick();
    chk("t5_flush_only", {ex_alu_op, ex_alu_src, ex_extop}, 0);
    flush = 1'b0;

    // ---- branch / jump decode, unknown funct
    instr = itype(6'h05, 5'd1, 5'd2, 16'd3);            // BNE
    tick();
    chk("bne", {ex_pc_src, ex_bne, ex_alu_op, ex_extop}, {2'b01, 1'b1, 4'd3, 1'b1});
    instr = {6'h03, 26'h10};                          // JAL
    tick();
    chk("jal", {ex_pc_src, ex_bne}, {2'b10, 1'b0});
    instr = rtype(5'd31, 5'd0, 5'd0, 6'h08);          // JR $31
    tick();
    chk("jr", ex_pc_src, 2'b11);
    instr = itype(6'h04, 5'd1, 5'd2, 16'd3);            // BEQ
    tick();
    chk("beq", {ex_pc_src, ex_bne}, {2'b01, 1'b0});
    chk("jal_link", {wb_regwr, wb_wsel}, {1'b1, 5'd31});
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h01);           // unknown funct
    tick();
    instr = NOP;
    tick(); tick();
    chk("unk_funct_wb", {wb_regwr, wb_wsel}, 0);

    // ---- hazard boundaries
    instr = itype(6'h23, 5'd1, 5'd0, 16'd0);            // LW $0
    tick();
    instr = rtype(5'd0, 5'd0, 5'd9, 6'h21);
    #1 chk("hz_r0", hazard_stall, 0);
    instr = itype(6'h23, 5'd1, 5'd16, 16'd0);           // LW $16
    tick();
    instr = itype(6'h0D, 5'd1, 5'd16, 16'd1);           // ORI $16,$1,1 (rt not read)
    #1 chk("hz_rt_unused", hazard_stall, 0);
    instr = itype(6'h2B, 5'd1, 5'd16, 16'd0);           // SW $16 (rt read)
    #1 chk("hz_rt_used", hazard_stall, 1);
    instr = NOP;
    tick();

    // ---- reset mid-operation
    instr = itype(6'h2B, 5'd1, 5'd2, 16'd0);            // SW
    tick();
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    tick();
    nRST = 1'b0;
    #1 chk("midrst", {ex_alu_op, ex_alu_src, mem_memwr, wb_regwr}, 0);
    instr = NOP;
    tick();
    nRST = 1'b1;
    tick(); tick();
    chk("midrst_after", {mem_memwr, wb_regwr}, 0);

    // ---- 6: HALT
    instr = HALT;
    tick();
    instr = NOP;
    chk("halt_c1", halt, 0);
    tick();
    chk("halt_c2", halt, 0);
    tick();
    chk("halt_c3", halt, 1);
    instr = itype(6'h2B, 5'd1, 5'd2, 16'd0);            // SW after halt
    tick();
    chk("halt_ex_bubble", {ex_alu_op, ex_alu_src}, 0);
    instr = rtype(5'd1, 5'd2, 5'd15, 6'h21);
    tick();
    chk("halt_no_memwr", mem_memwr, 0);
    tick(); tick();
    chk("halt_sticky", {halt, wb_regwr, mem_memwr}, {1'b1, 1'b0, 1'b0});
    nRST = 1'b0;
    #1 chk("halt_clear", halt, 0);
    tick();
    nRST = 1'b1;
    instr = NOP;
    tick();
    chk("halt_after_rst", halt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
